// File: rtl/vp_arb_pkg.sv
// Shared constants for the vector-processor arbiter: widths, opcodes, FSM states.
// Imported by vp_arbiter and rr_picker.
package vp_arb_pkg;

  localparam int DATA_WIDTH_DEF   = 16;
  localparam int VECTOR_WIDTH_DEF = 4;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;

  localparam logic [15:0] FP_ONE = 16'h0100;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index after last_i, wrapping.
// Ports: valid_i/last_i in; gnt_o (one-hot), idx_o, any_o out.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last_i) + k) % N);
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vp_arbiter.sv
// Round-robin sharing of one vector processor among NUM_REQ requesters.
// Ports: req_* handshake in, rsp_* strobe out, vp_* to/from the VP; VP_ARB_TIMEOUT_EN adds watchdog.
module vp_arbiter
  import vp_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int VECTOR_WIDTH   = VECTOR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*4-1:0]               req_operation,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_a,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_scalar,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] rsp_result,
  output logic                               rsp_error,
  output logic                               vp_start,
  output logic [3:0]                         vp_operation,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_vec_a,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_vec_b,
  output logic [DATA_WIDTH-1:0]              vp_scalar,
  input  logic                               vp_busy,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_result,
  input  logic                               vp_result_valid,
  output logic                               arb_busy,
  output logic [$clog2(NUM_REQ)-1:0]         owner_id
);

  localparam int VW = VECTOR_WIDTH * DATA_WIDTH;
  localparam int OW = $clog2(NUM_REQ);

  state_e state_q, state_d;

  logic [OW-1:0]         last_q, last_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic                  vp_start_q, vp_start_d;
  logic [3:0]            vp_op_q, vp_op_d;
  logic [VW-1:0]         vp_a_q, vp_a_d;
  logic [VW-1:0]         vp_b_q, vp_b_d;
  logic [DATA_WIDTH-1:0] vp_s_q, vp_s_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [VW-1:0]         rsp_res_q, rsp_res_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept;
  logic               done;
  logic               tmo;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept = (state_q == IDLE) && !vp_busy && pick_any;
  // The strobe is not trusted during the start cycle.
  assign done   = (state_q == WAIT) && !vp_start_q
                  && vp_result_valid;

  assign req_ready = ((state_q == IDLE) && !vp_busy)
                     ? pick_gnt : '0;

`ifdef VP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (state_q == WAIT)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A real result in the same cycle takes precedence.
  assign tmo = (state_q == WAIT) && !done
               && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: if (done || tmo) state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    vp_start_d  = 1'b0;
    vp_op_d     = vp_op_q;
    vp_a_d      = vp_a_q;
    vp_b_d      = vp_b_q;
    vp_s_d      = vp_s_q;
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = 1'b0;
    if (accept) begin
      last_d     = pick_idx;
      owner_d    = pick_idx;
      vp_start_d = 1'b1;
      vp_op_d    = req_operation[4*pick_idx +: 4];
      vp_a_d     = req_vec_a[VW*pick_idx +: VW];
      vp_b_d     = req_vec_b[VW*pick_idx +: VW];
      vp_s_d     = req_scalar[DATA_WIDTH*pick_idx +: DATA_WIDTH];
    end
    if (done) begin
      rsp_valid_d = NUM_REQ'(1) << owner_q;
      rsp_res_d   = vp_result;
    end else if (tmo) begin
      rsp_valid_d = NUM_REQ'(1) << owner_q;
      rsp_res_d   = '0;
      rsp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= OW'(NUM_REQ - 1);
      owner_q     <= '0;
      vp_start_q  <= 1'b0;
      vp_op_q     <= '0;
      vp_a_q      <= '0;
      vp_b_q      <= '0;
      vp_s_q      <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      vp_start_q  <= vp_start_d;
      vp_op_q     <= vp_op_d;
      vp_a_q      <= vp_a_d;
      vp_b_q      <= vp_b_d;
      vp_s_q      <= vp_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign vp_start     = vp_start_q;
  assign vp_operation = vp_op_q;
  assign vp_vec_a     = vp_a_q;
  assign vp_vec_b     = vp_b_q;
  assign vp_scalar    = vp_s_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_res_q;
  assign rsp_error    = rsp_err_q;
  assign arb_busy     = (state_q == WAIT);
  assign owner_id     = owner_q;

endmodule

// File: tb/tb_vp_arbiter.sv
// Randomized + directed bench for vp_arbiter against a cycle-level reference model.
// Define VP_ARB_TIMEOUT_EN to exercise the watchdog with a 16-cycle limit.
module tb_vp_arbiter;
  import vp_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int VWD = 4;
  localparam int VW  = VWD * DW;
  localparam int OW  = 2;
`ifdef VP_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*4-1:0]    req_operation;
  logic [N*VW-1:0]   req_vec_a;
  logic [N*VW-1:0]   req_vec_b;
  logic [N*DW-1:0]   req_scalar;
  logic [N-1:0]      rsp_valid;
  logic [VW-1:0]     rsp_result;
  logic              rsp_error;
  logic              vp_start;
  logic [3:0]        vp_operation;
  logic [VW-1:0]     vp_vec_a;
  logic [VW-1:0]     vp_vec_b;
  logic [DW-1:0]     vp_scalar;
  logic              vp_busy;
  logic [VW-1:0]     vp_result;
  logic              vp_result_valid;
  logic              arb_busy;
  logic [OW-1:0]     owner_id;

  logic [3:0]    op [N];
  logic [VW-1:0] va [N];
  logic [VW-1:0] vb [N];
  logic [DW-1:0] sc [N];

  always_comb begin
    req_operation = '0;
    req_vec_a     = '0;
    req_vec_b     = '0;
    req_scalar    = '0;
    for (int i = 0; i < N; i++) begin
      req_operation[4*i +: 4] = op[i];
      req_vec_a[VW*i +: VW]   = va[i];
      req_vec_b[VW*i +: VW]   = vb[i];
      req_scalar[DW*i +: DW]  = sc[i];
    end
  end

  vp_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .VECTOR_WIDTH   (VWD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_operation   (req_operation),
    .req_vec_a       (req_vec_a),
    .req_vec_b       (req_vec_b),
    .req_scalar      (req_scalar),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_error       (rsp_error),
    .vp_start        (vp_start),
    .vp_operation    (vp_operation),
    .vp_vec_a        (vp_vec_a),
    .vp_vec_b        (vp_vec_b),
    .vp_scalar       (vp_scalar),
    .vp_busy         (vp_busy),
    .vp_result       (vp_result),
    .vp_result_valid (vp_result_valid),
    .arb_busy        (arb_busy),
    .owner_id        (owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: abstract arbiter state kept as plain ints.
  int            m_last;
  int            m_owner;
  bit            m_wait;
  int            m_age;
  logic [3:0]    m_op;
  logic [VW-1:0] m_a, m_b;
  logic [DW-1:0] m_s;
  logic          e_start;
  logic [N-1:0]  e_rspv;
  logic          e_err;
  logic [VW-1:0] e_res;

  task automatic m_reset();
    m_last  = N - 1;
    m_owner = 0;
    m_wait  = 0;
    m_age   = 0;
    m_op    = '0;
    m_a     = '0;
    m_b     = '0;
    m_s     = '0;
    e_start = 0;
    e_rspv  = '0;
    e_err   = 0;
    e_res   = '0;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op[i] = 4'($urandom);
      va[i] = {$urandom(), $urandom()};
      vb[i] = {$urandom(), $urandom()};
      sc[i] = DW'($urandom);
    end
  endtask

  task automatic post_checks();
    chk("vp_start", vp_start, e_start);
    chk("vp_operation", vp_operation, m_op);
    chk("vp_vec_a", vp_vec_a, m_a);
    chk("vp_vec_b", vp_vec_b, m_b);
    chk("vp_scalar", vp_scalar, m_s);
    chk("rsp_valid", rsp_valid, e_rspv);
    chk("rsp_error", rsp_error, e_err);
    chk("rsp_result", rsp_result, e_res);
    chk("arb_busy", arb_busy, m_wait);
    chk("owner_id", owner_id, m_owner);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic bsy,
                     input logic rvv, input logic [VW-1:0] res);
    int w;
    req_valid       = v;
    vp_busy         = bsy;
    vp_result_valid = rvv;
    vp_result       = res;
    #1;
    w = (!m_wait && !bsy) ? pick(v, m_last) : -1;
    chk("req_ready", req_ready, (w >= 0) ? (N'(1) << w) : '0);
    e_start = 0;
    e_rspv  = '0;
    e_err   = 0;
    if (w >= 0) begin
      m_op    = op[w];
      m_a     = va[w];
      m_b     = vb[w];
      m_s     = sc[w];
      e_start = 1;
      m_owner = w;
      m_last  = w;
      m_wait  = 1;
      m_age   = 0;
    end else if (m_wait) begin
      if (m_age > 0 && rvv) begin
        e_rspv = N'(1) << m_owner;
        e_res  = res;
        m_wait = 0;
      end
`ifdef VP_ARB_TIMEOUT_EN
      else if (m_age == TMO - 1) begin
        e_rspv = N'(1) << m_owner;
        e_res  = '0;
        e_err  = 1;
        m_wait = 0;
      end
`endif
      else m_age++;
    end
    @(posedge clk);
    #1;
    post_checks();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_vp_start", vp_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_vp_op", vp_operation, 0);
    chk("rst_rsp_result", rsp_result, 0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_wait; i++)
      cyc('0, 1'b0, 1'b1, {$urandom(), $urandom()});
    chk("drain_idle", arb_busy, 0);
  endtask

  initial begin
    logic [VW-1:0] r;
    int ng;
    int cd;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req_valid       = '0;
    vp_busy         = 1'b0;
    vp_result_valid = 1'b0;
    vp_result       = '0;
    rand_ops();
    m_reset();
    @(posedge clk);
    #1;
    mid_reset();

    // Single scale op, VP answers 3 cycles after start.
    op[0] = OP_SCALE;
    sc[0] = FP_ONE;
    va[0] = {16'hFF00, 16'h0000, 16'h0000, 16'hFF00};
    cyc(4'b0001, 0, 0, '0);
    chk("t1_start", vp_start, 1);
    chk("t1_op", vp_operation, 4);
    chk("t1_scalar", vp_scalar, 16'h0100);
    chk("t1_vec_a", vp_vec_a, 64'hFF00_0000_0000_FF00);
    for (int i = 0; i < 3; i++) cyc('0, 0, 0, '0);
    r = 64'h1234_5678_9ABC_DEF0;
    cyc('0, 0, 1, r);
    chk("t1_rspv", rsp_valid, 4'b0001);
    chk("t1_rsp", rsp_result, r);
    cyc('0, 0, 0, '0);

    // All valid, 2-cycle VP: grants rotate 0..3 twice.
    mid_reset();
    rand_ops();
    ng = 0;
    cd = -1;
    for (int c = 0; c < 200 && (ng < 8 || m_wait); c++) begin
      cyc((ng < 8) ? 4'b1111 : 4'b0000, 0, (cd == 0),
          {$urandom(), $urandom()});
      if (cd >= 0) cd--;
      if (vp_start) begin
        chk("rr_order", owner_id, ng % N);
        ng++;
        cd = 2;
      end
    end
    chk("rr_count", ng, 8);

    // vp_busy blocks the grant until released.
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1, 0, '0);
    chk("busy_noready", req_ready, 0);
    cyc(4'b0010, 0, 0, '0);
    chk("busy_grant", owner_id, 1);
    drain();

    // Spurious strobes: in IDLE and in the start cycle.
    cyc('0, 0, 1, 64'hDEAD);
    cyc('0, 0, 1, 64'hBEEF);
    chk("idle_strobe", rsp_valid, 0);
    cyc(4'b0001, 0, 0, '0);
    cyc('0, 0, 1, 64'h1111);
    chk("start_strobe", rsp_valid, 0);
    chk("start_busy", arb_busy, 1);
    r = 64'h2222_3333_4444_5555;
    cyc('0, 0, 1, r);
    chk("late_rspv", rsp_valid, 4'b0001);
    chk("late_rsp", rsp_result, r);

    // Reset while waiting discards the result.
    cyc(4'b0100, 0, 0, '0);
    cyc('0, 0, 0, '0);
    mid_reset();
    cyc('0, 0, 1, 64'h7777);
    chk("rst_discard", rsp_valid, 0);
    cyc(4'b1111, 0, 0, '0);
    chk("rst_prio", owner_id, 0);
    drain();

`ifdef VP_ARB_TIMEOUT_EN
    // Silent VP: watchdog answers with an error.
    cyc(4'b1000, 0, 0, '0);
    ng = 0;
    for (int i = 0; i < 40; i++) begin
      cyc('0, 0, 0, '0);
      ng++;
      if (rsp_valid != '0) break;
    end
    chk("tmo_len", ng, TMO);
    chk("tmo_err", rsp_error, 1);
    chk("tmo_res", rsp_result, 0);
    cyc(4'b0001, 0, 0, '0);
    chk("tmo_next", vp_start, 1);
    drain();
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_ops();
      if ($urandom_range(0, 399) == 0) mid_reset();
      cyc(N'($urandom_range(0, 15) & $urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0),
          {$urandom(), $urandom()});
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vp_arbiter.md
Name: vp_arbiter

Overview:
- Shares one vector processor (VP) between NUM_REQ shader-pipeline requesters using round-robin arbitration.
- Accepts one operation at a time, drives the VP start/operand interface, waits for the VP result and returns it to the owning requester.
- Sits between the per-tile shader pipelines and the single VP instance in the top-level render path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, scalar/lane width (8.8 fixed point)
- VECTOR_WIDTH, 4, lanes per vector
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with VP_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester operation request; held until accepted
- req_ready  out  NUM_REQ  one-hot accept; transfer occurs when valid&ready
- req_operation  in  NUM_REQ*4  opcode per requester; slot i at [4i+3:4i]
- req_vec_a  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand A per requester
- req_vec_b  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand B per requester
- req_scalar  in  NUM_REQ*DATA_WIDTH  scalar per requester
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe to the owner
- rsp_result  out  VECTOR_WIDTH*DATA_WIDTH  result; valid while rsp_valid is nonzero
- rsp_error  out  1  set with rsp_valid on timeout; always 0 without the macro
- vp_start  out  1  one-cycle VP start pulse
- vp_operation  out  4  VP opcode
- vp_vec_a  out  VECTOR_WIDTH*DATA_WIDTH  VP operand A
- vp_vec_b  out  VECTOR_WIDTH*DATA_WIDTH  VP operand B
- vp_scalar  out  DATA_WIDTH  VP scalar
- vp_busy  in  1  VP busy; blocks new grants
- vp_result  in  VECTOR_WIDTH*DATA_WIDTH  VP result
- vp_result_valid  in  1  VP result strobe
- arb_busy  out  1  high while in WAIT
- owner_id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset values: all outputs 0. State IDLE. last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, WAIT.
- IDLE:
  - req_ready is combinational: one-hot of the round-robin winner when state==IDLE, !vp_busy and |req_valid; otherwise all 0.
  - Winner is the first valid index searching last_grant+1 upward, wrapping modulo NUM_REQ.
  - On the accept edge:
    - latch the winner's operation, vec_a, vec_b and scalar into vp_* registers;
    - set vp_start=1 for exactly one cycle;
    - set owner_id=winner and last_grant=winner;
    - go to WAIT.
- WAIT:
  - vp_start returns to 0 after the first cycle; vp_* operands hold stable until the next accept.
  - vp_result_valid is ignored in the cycle vp_start is high.
  - On vp_result_valid thereafter: rsp_result<=vp_result, rsp_valid<=(1<<owner_id) for one cycle, rsp_error<=0, go to IDLE.
- Latency: accept at edge T; vp_start high in cycle T+1; VP result_valid at cycle R; rsp_valid high in cycle R+1.
- Back-to-back: a new grant may be issued in the same cycle that rsp_valid is high.
- vp_result_valid arriving while in IDLE is ignored and produces no rsp_valid.
- A requester that drops req_valid before being accepted loses its turn silently; no state changes.
- vp_busy high in IDLE: no req_ready, no grant.
- All requesters valid: grants cycle 0,1,2,3,0,... Fairness bound is NUM_REQ-1 operations of wait.
- vp_done is not consumed; completion is defined by vp_result_valid only.
- Reset mid-operation: returns immediately to IDLE with reset values. The in-flight result is discarded and any later vp_result_valid is ignored.
- rsp_result holds its last value between strobes.

Optional Feature:
- VP_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without vp_result_valid: rsp_valid<=(1<<owner_id), rsp_error<=1, rsp_result<=0, go to IDLE.
  - vp_result_valid in the same cycle as the timeout wins (normal response, rsp_error=0).
- Not defined: no counter is built; WAIT lasts until vp_result_valid; rsp_error is tied 0.

Decomposition:
- Package vp_arb_pkg:
  - DATA_WIDTH/VECTOR_WIDTH defaults;
  - VP opcode constants (OP_ADD=0, OP_SUB=1, OP_SCALE=4, OP_LENGTH=5);
  - state encoding IDLE/WAIT;
  - FP_ONE=16'h0100.
- Sub-module rr_picker: combinational round-robin winner from a valid vector and last_grant.
  - Outputs: one-hot grant, index, any.
  - Reused by the later memory-port arbiter.

Test Plan:
- Reset, then req_valid=4'b0001 with op=4, scalar=16'h0100, vec_a={FF00,0,0,FF00}.
  - Expect req_ready=0001; vp_start for one cycle on the next cycle; vp_operation=4, vp_scalar=0100.
  - VP returns result 3 cycles later -> rsp_valid=0001 one cycle later, rsp_result equals vp_result.
- req_valid=4'b1111 held for 8 operations with a 2-cycle VP model -> grant order 0,1,2,3,0,1,2,3; each rsp_valid matches the granted index.
- vp_busy=1 in IDLE with req_valid=0010 -> req_ready stays 0. Release vp_busy -> grant 1 in the same cycle.
- Spurious vp_result_valid in IDLE -> rsp_valid stays 0. vp_result_valid in the vp_start cycle -> ignored; the response is taken only on a later strobe.
- Assert rst_n=0 mid-WAIT, then deliver vp_result_valid after reset -> no rsp_valid; next grant goes to requester 0 first.
- With VP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, VP never responds -> rsp_valid to owner 16 WAIT cycles after accept, rsp_error=1, rsp_result=0; the arbiter accepts the next request afterwards.
